mips_decode_exec: RTL and testbench
===================================

# mips_decode_exec

Combined decode/execute slice of the five-stage MIPS pipeline. It merges main control (opcode to control signals), ALU control (aluop/funct to ALU operation) and the 32-bit ALU. It takes an instruction word plus its two register operands and produces one registered EX/MEM bundle: ALU result, zero flag, destination register and the memory/writeback/branch controls.

## Interface
- No parameters; data width fixed at 32 bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- hold  in  1  when high, the output register keeps its value.
- flush  in  1  when high, the output register loads a bubble (all zeros); overrides hold.
- instr  in  32  instruction word.
- rs_data  in  32  operand A (rs value, already forwarded).
- rt_data  in  32  rt value (already forwarded).
- result  out  32  registered ALU result.
- zero  out  1  registered flag: result == 0.
- store_data  out  32  registered rt_data (sw write data).
- wrreg  out  5  registered destination: rd if regdst, else rt.
- regwrite, memread, memwrite, memtoreg  out  1 each  registered controls.
- branch_eq, branch_ne, jump  out  1 each  registered controls.

## Operation
- Instruction fields: opcode = instr[31:26], rt = instr[20:16], rd = instr[15:11], funct = instr[5:0]. seimm is instr[15:0] sign-extended to 32 bits.
- Main control, listed as opcode: asserted signals (all others 0):
  - 000000 R-type: regdst, regwrite, aluop=10
  - 100011 lw: memread, memtoreg, alusrc, regwrite, aluop=00
  - 101011 sw: memwrite, alusrc, aluop=00
  - 000100 beq: branch_eq, aluop=01
  - 000101 bne: branch_ne, aluop=01
  - 001000 addi: alusrc, regwrite, aluop=00
  - 000010 j: jump, aluop=00
  - any other opcode: every control is 0 (NOP); the ALU still computes AND.
- ALU control, aluop to aluctl:
  - 00 gives add (2).
  - 01 gives sub (6).
  - 10 decodes funct: 100000 add (2), 100010 sub (6), 100100 and (0), 100101 or (1), 100110 xor (13), 100111 nor (12), 101010 slt (7). Any other funct gives 0 (and).
  - 11 gives 0.
- ALU inputs: a = rs_data; b = alusrc ? seimm : rt_data.
- ALU operations by aluctl:
  - 0 a&b; 1 a|b; 2 a+b, wrapping mod 2^32 with no overflow trap; 6 a−b, wrapping.
  - 7 slt: 32'd1 if $signed(a) < $signed(b), else 0.
  - 12 ~(a|b); 13 a^b; any other code gives 0.
- zero = (ALU out == 0), computed combinationally, then registered.
- Each rising clk loads the output register as follows:
  - flush=1: all outputs load 0.
  - else hold=1: all outputs unchanged.
  - else: load the computed values.

## Timing
- Decode, ALU-control and ALU are purely combinational. Latency is exactly 1 clk from instr/operands to outputs.
- rst_n low immediately forces every output to 0, regardless of clk. Outputs stay 0 while rst_n is low.
- Reset asserted mid-operation discards the in-flight value.
- The first load happens on the first rising clk after rst_n deasserts.
- flush and hold asserted together: flush wins, so outputs go to 0.
- A bubble (all zeros) is harmless: no regwrite, memwrite, branch or jump. Its zero output is 0 by definition, not computed.

## Test plan
- R-type add (instr 0x00221820, rs_data=5, rt_data=7), then one clk: result=12, wrreg=3, regwrite=1, regdst path taken, zero=0.
- lw (instr 0x8C410010, rs_data=0x100): result=0x110, wrreg=1, memread=memtoreg=regwrite=1. Repeat with imm 0xFFFC: result=0xFC.
- beq with rs_data=rt_data=9: zero=1, branch_eq=1, regwrite=0. bne with 9 vs 8: zero=0, branch_ne=1.
- slt signed: a=0xFFFFFFFF, b=1 gives result=1; a=1, b=0xFFFFFFFF gives 0. sub 3−5 gives 0xFFFFFFFE.
- Register control:
  - hold=1 for 2 clks while instr changes: outputs frozen.
  - flush=1 (with hold=1): all outputs 0 on the next edge.
  - Pulse rst_n low between edges: outputs clear immediately.
- Unknown opcode 0x3F: all controls 0.

Source files
------------

// File: rtl/mips_decode_exec.sv
// mips_decode_exec: decode/execute slice of a five-stage MIPS pipeline.
// Main control, ALU control and a 32-bit ALU are combinational. Their
// results are captured in a single EX/MEM output register that supports
// hold (stall) and flush (bubble insertion).
module mips_decode_exec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] result,
  output logic        zero,
  output logic [31:0] store_data,
  output logic [4:0]  wrreg,
  output logic        regwrite,
  output logic        memread,
  output logic        memwrite,
  output logic        memtoreg,
  output logic        branch_eq,
  output logic        branch_ne,
  output logic        jump
);

  // Opcodes recognised by the main decoder.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes.
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Main-control to ALU-control encoding.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  // ALU operation codes.
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_XOR = 4'd13;

  // Instruction fields.
  logic [5:0]  opcode;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [31:0] seimm;

  assign opcode = instr[31:26];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign seimm  = {{16{instr[15]}}, instr[15:0]};

  // The rs index and shamt are not needed here: rs arrives already read and
  // forwarded, and no shift operations are implemented.
  logic unused_fields;
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  // Decoded controls.
  logic       regdst;
  logic       alusrc;
  logic [1:0] aluop;
  logic       dec_regwrite;
  logic       dec_memread;
  logic       dec_memwrite;
  logic       dec_memtoreg;
  logic       dec_branch_eq;
  logic       dec_branch_ne;
  logic       dec_jump;

  // ALU datapath.
  logic [3:0]  aluctl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic [4:0]  dest_reg;

  // Main control: opcode to datapath/memory/writeback controls.
  // Unknown opcodes decode to a NOP; aluop is steered to the AND encoding so
  // the ALU still produces a&b for them.
  always_comb begin
    regdst        = 1'b0;
    alusrc        = 1'b0;
    aluop         = ALUOP_AND;
    dec_regwrite  = 1'b0;
    dec_memread   = 1'b0;
    dec_memwrite  = 1'b0;
    dec_memtoreg  = 1'b0;
    dec_branch_eq = 1'b0;
    dec_branch_ne = 1'b0;
    dec_jump      = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        regdst       = 1'b1;
        dec_regwrite = 1'b1;
        aluop        = ALUOP_FUNCT;
      end
      OP_LW: begin
        dec_memread  = 1'b1;
        dec_memtoreg = 1'b1;
        alusrc       = 1'b1;
        dec_regwrite = 1'b1;
        aluop        = ALUOP_ADD;
      end
      OP_SW: begin
        dec_memwrite = 1'b1;
        alusrc       = 1'b1;
        aluop        = ALUOP_ADD;
      end
      OP_BEQ: begin
        dec_branch_eq = 1'b1;
        aluop         = ALUOP_SUB;
      end
      OP_BNE: begin
        dec_branch_ne = 1'b1;
        aluop         = ALUOP_SUB;
      end
      OP_ADDI: begin
        alusrc       = 1'b1;
        dec_regwrite = 1'b1;
        aluop        = ALUOP_ADD;
      end
      OP_J: begin
        dec_jump = 1'b1;
        aluop    = ALUOP_ADD;
      end
      default: begin
        aluop = ALUOP_AND;
      end
    endcase
  end

  // ALU control: aluop, and funct for R-type, select the ALU operation.
  always_comb begin
    aluctl = ALU_AND;
    case (aluop)
      ALUOP_ADD: aluctl = ALU_ADD;
      ALUOP_SUB: aluctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  aluctl = ALU_ADD;
          FN_SUB:  aluctl = ALU_SUB;
          FN_AND:  aluctl = ALU_AND;
          FN_OR:   aluctl = ALU_OR;
          FN_XOR:  aluctl = ALU_XOR;
          FN_NOR:  aluctl = ALU_NOR;
          FN_SLT:  aluctl = ALU_SLT;
          default: aluctl = ALU_AND;
        endcase
      end
      default: aluctl = ALU_AND;
    endcase
  end

  assign alu_a    = rs_data;
  assign alu_b    = alusrc ? seimm : rt_data;
  assign dest_reg = regdst ? rd : rt;

  // 32-bit ALU; add and sub wrap silently, slt compares as signed.
  always_comb begin
    alu_out = 32'd0;
    case (aluctl)
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      ALU_ADD: alu_out = alu_a + alu_b;
      ALU_SUB: alu_out = alu_a - alu_b;
      ALU_SLT: alu_out = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      ALU_NOR: alu_out = ~(alu_a | alu_b);
      ALU_XOR: alu_out = alu_a ^ alu_b;
      default: alu_out = 32'd0;
    endcase
  end

  assign alu_zero = (alu_out == 32'd0);

  // EX/MEM register: flush inserts an all-zero bubble (zero flag included),
  // hold freezes the stage, otherwise capture the freshly computed bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result     <= 32'd0;
      zero       <= 1'b0;
      store_data <= 32'd0;
      wrreg      <= 5'd0;
      regwrite   <= 1'b0;
      memread    <= 1'b0;
      memwrite   <= 1'b0;
      memtoreg   <= 1'b0;
      branch_eq  <= 1'b0;
      branch_ne  <= 1'b0;
      jump       <= 1'b0;
    end else if (flush) begin
      result     <= 32'd0;
      zero       <= 1'b0;
      store_data <= 32'd0;
      wrreg      <= 5'd0;
      regwrite   <= 1'b0;
      memread    <= 1'b0;
      memwrite   <= 1'b0;
      memtoreg   <= 1'b0;
      branch_eq  <= 1'b0;
      branch_ne  <= 1'b0;
      jump       <= 1'b0;
    end else if (!hold) begin
      result     <= alu_out;
      zero       <= alu_zero;
      store_data <= rt_data;
      wrreg      <= dest_reg;
      regwrite   <= dec_regwrite;
      memread    <= dec_memread;
      memwrite   <= dec_memwrite;
      memtoreg   <= dec_memtoreg;
      branch_eq  <= dec_branch_eq;
      branch_ne  <= dec_branch_ne;
      jump       <= dec_jump;
    end
  end

endmodule

// File: tb/tb_mips_decode_exec.sv
// tb_mips_decode_exec: directed scoreboard bench for mips_decode_exec.
// Each step drives an instruction, queues the hand-derived EX/MEM bundle,
// clocks once and compares the registered outputs against the queue head.
module tb_mips_decode_exec;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic        flush;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] result;
  logic        zero;
  logic [31:0] store_data;
  logic [4:0]  wrreg;
  logic        regwrite;
  logic        memread;
  logic        memwrite;
  logic        memtoreg;
  logic        branch_eq;
  logic        branch_ne;
  logic        jump;

  // Control bundle order: regwrite, memread, memwrite, memtoreg,
  // branch_eq, branch_ne, jump.
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_RW   = 7'b1000000;
  localparam logic [6:0] C_LW   = 7'b1101000;
  localparam logic [6:0] C_SW   = 7'b0010000;
  localparam logic [6:0] C_BEQ  = 7'b0000100;
  localparam logic [6:0] C_BNE  = 7'b0000010;
  localparam logic [6:0] C_J    = 7'b0000001;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic [31:0] store_data;
    logic [4:0]  wrreg;
    logic [6:0]  ctl;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  mips_decode_exec dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (hold),
    .flush      (flush),
    .instr      (instr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .result     (result),
    .zero       (zero),
    .store_data (store_data),
    .wrreg      (wrreg),
    .regwrite   (regwrite),
    .memread    (memread),
    .memwrite   (memwrite),
    .memtoreg   (memtoreg),
    .branch_eq  (branch_eq),
    .branch_ne  (branch_ne),
    .jump       (jump)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t mk(input logic [31:0] r, input logic z,
                              input logic [31:0] sd, input logic [4:0] wr,
                              input logic [6:0] c);
    exp_t e;
    e.result     = r;
    e.zero       = z;
    e.store_data = sd;
    e.wrreg      = wr;
    e.ctl        = c;
    return e;
  endfunction

  task automatic apply_stimulus(input logic [31:0] i, input logic [31:0] a,
                                input logic [31:0] b, input exp_t e);
    instr   = i;
    rs_data = a;
    rt_data = b;
    sb.push_back(e);
  endtask

  task automatic check_output(input string tag);
    exp_t       e;
    logic [6:0] ctl;
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("[TB] FAIL %s.queue got=empty exp=entry", tag);
    end
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      ctl = {regwrite, memread, memwrite, memtoreg, branch_eq, branch_ne, jump};
      total++;
      assert (result === e.result) else begin
        bad++;
        $error("[TB] FAIL %s.result got=%h exp=%h", tag, result, e.result);
      end
      total++;
      assert (zero === e.zero) else begin
        bad++;
        $error("[TB] FAIL %s.zero got=%b exp=%b", tag, zero, e.zero);
      end
      total++;
      assert (store_data === e.store_data) else begin
        bad++;
        $error("[TB] FAIL %s.store_data got=%h exp=%h", tag, store_data, e.store_data);
      end
      total++;
      assert (wrreg === e.wrreg) else begin
        bad++;
        $error("[TB] FAIL %s.wrreg got=%0d exp=%0d", tag, wrreg, e.wrreg);
      end
      total++;
      assert (ctl === e.ctl) else begin
        bad++;
        $error("[TB] FAIL %s.ctl got=%b exp=%b", tag, ctl, e.ctl);
      end
    end
  endtask

  task automatic step(input string tag, input logic [31:0] i,
                      input logic [31:0] a, input logic [31:0] b, input exp_t e);
    apply_stimulus(i, a, b, e);
    @(posedge clk);
    #1;
    check_output(tag);
  endtask

  initial begin
    rst_n   = 1'b0;
    hold    = 1'b0;
    flush   = 1'b0;
    instr   = 32'h00221820;
    rs_data = 32'd5;
    rt_data = 32'd7;

    // Reset held across a clock edge: everything stays zero.
    #12;
    sb.push_back(mk(32'd0, 1'b0, 32'd0, 5'd0, C_NONE));
    check_output("reset");
    #1 rst_n = 1'b1;

    // R-type arithmetic/logic.
    step("add",  32'h00221820, 32'd5, 32'd7, mk(32'd12, 1'b0, 32'd7, 5'd3, C_RW));
    step("sub",  32'h00221822, 32'd3, 32'd5, mk(32'hFFFFFFFE, 1'b0, 32'd5, 5'd3, C_RW));
    step("slt1", 32'h0022182A, 32'hFFFFFFFF, 32'd1, mk(32'd1, 1'b0, 32'd1, 5'd3, C_RW));
    step("slt0", 32'h0022182A, 32'd1, 32'hFFFFFFFF, mk(32'd0, 1'b1, 32'hFFFFFFFF, 5'd3, C_RW));
    step("nor",  32'h00221827, 32'h0F0F0000, 32'h00FF00FF, mk(32'hF000FF00, 1'b0, 32'h00FF00FF, 5'd3, C_RW));
    step("xor",  32'h00221826, 32'hFFFF0000, 32'h0F0F0F0F, mk(32'hF0F00F0F, 1'b0, 32'h0F0F0F0F, 5'd3, C_RW));
    step("badfn",32'h0022183F, 32'hFF00FF00, 32'h0FF00FF0, mk(32'h0F000F00, 1'b0, 32'h0FF00FF0, 5'd3, C_RW));

    // Memory, immediate, branch and jump instructions.
    step("lw",   32'h8C410010, 32'h100, 32'hAA, mk(32'h110, 1'b0, 32'hAA, 5'd1, C_LW));
    step("lwneg",32'h8C41FFFC, 32'h100, 32'hAA, mk(32'hFC, 1'b0, 32'hAA, 5'd1, C_LW));
    step("sw",   32'hAC410008, 32'h200, 32'h1234, mk(32'h208, 1'b0, 32'h1234, 5'd1, C_SW));
    step("addi", 32'h2041FFFF, 32'd0, 32'd3, mk(32'hFFFFFFFF, 1'b0, 32'd3, 5'd1, C_RW));
    step("beq",  32'h10220003, 32'd9, 32'd9, mk(32'd0, 1'b1, 32'd9, 5'd2, C_BEQ));
    step("bne",  32'h14220003, 32'd9, 32'd8, mk(32'd1, 1'b0, 32'd8, 5'd2, C_BNE));
    step("j",    32'h08000010, 32'd4, 32'd6, mk(32'd10, 1'b0, 32'd6, 5'd0, C_J));
    step("nop3f",32'hFC221820, 32'h0000F0F0, 32'h0000FF00, mk(32'h0000F000, 1'b0, 32'h0000FF00, 5'd2, C_NONE));

    // Known value, then hold for two edges while the inputs change.
    step("or",   32'h00221825, 32'd1, 32'd2, mk(32'd3, 1'b0, 32'd2, 5'd3, C_RW));
    hold = 1'b1;
    step("hold1", 32'h8C410010, 32'h100, 32'hAA, mk(32'd3, 1'b0, 32'd2, 5'd3, C_RW));
    step("hold2", 32'h10220003, 32'd9, 32'd9, mk(32'd3, 1'b0, 32'd2, 5'd3, C_RW));

    // Flush together with hold: bubble wins.
    flush = 1'b1;
    step("flush", 32'h00221820, 32'd5, 32'd7, mk(32'd0, 1'b0, 32'd0, 5'd0, C_NONE));
    flush = 1'b0;
    hold  = 1'b0;

    // Reload, then pulse reset between edges.
    step("reload", 32'h00221820, 32'd5, 32'd7, mk(32'd12, 1'b0, 32'd7, 5'd3, C_RW));
    #1 rst_n = 1'b0;
    #1;
    sb.push_back(mk(32'd0, 1'b0, 32'd0, 5'd0, C_NONE));
    check_output("rstpulse");
    #1 rst_n = 1'b1;
    step("postrst", 32'h8C410010, 32'h100, 32'hAA, mk(32'h110, 1'b0, 32'hAA, 5'd1, C_LW));

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("[TB] FAIL leftover got=%0d exp=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
